// File: rtl/coin_return_sequencer.sv
// rtl/coin_return_sequencer.sv - inactivity timer and greedy one-coin-per-handshake change return (optional COIN_STOCK_EN)
module coin_return_sequencer #(
    parameter int NUM_COINS   = 3,
    parameter int TOTAL_BITS  = 31,
    parameter int WAIT_CYCLES = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [32*NUM_COINS-1:0] i_coin_value,
    input  logic [NUM_COINS-1:0]    i_input_coin,
    input  logic                    i_output_item,
    input  logic                    i_trigger_return,
    input  logic [TOTAL_BITS-1:0]   i_current_total,
`ifdef COIN_STOCK_EN
    input  logic [NUM_COINS-1:0]    i_coin_empty,
`endif
    output logic [NUM_COINS-1:0]    o_return_coin,
    output logic                    o_return_valid,
    input  logic                    i_return_ready,
    output logic                    o_busy,
    output logic                    o_return_done,
    output logic [TOTAL_BITS-1:0]   o_remainder,
    output logic [31:0]             o_wait_time
);

    localparam int CMP_W = (TOTAL_BITS > 32) ? TOTAL_BITS : 32;
    localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
    localparam logic [31:0] WAIT_LOAD = 32'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        RETURN = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [TOTAL_BITS-1:0]  remaining;
    logic [IDX_W-1:0]       cur_idx;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_found;
    logic [NUM_COINS-1:0]   coin_empty;
    logic [CMP_W-1:0]       rem_ext;
    logic [CMP_W-1:0]       coin_ext;
    logic [31:0]            cur_value;
    logic                   act;
    logic                   accept;
    logic                   withdraw;

`ifdef COIN_STOCK_EN
    assign coin_empty = i_coin_empty;
`else
    assign coin_empty = '0;
`endif

    assign act       = (|i_input_coin) || i_output_item;
    assign accept    = o_return_valid && i_return_ready;
    assign withdraw  = |(o_return_coin & coin_empty);
    assign rem_ext   = CMP_W'(remaining);
    assign cur_value = i_coin_value[32*cur_idx +: 32];

    // Greedy pick: highest-index denomination that fits the balance and is in stock
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        coin_ext  = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            coin_ext = CMP_W'(i_coin_value[32*k +: 32]);
            if ((coin_ext <= rem_ext) && !coin_empty[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and state-decoded outputs; activity always outranks a return request
    always_comb begin
        next_state    = state;
        o_busy        = 1'b0;
        o_return_done = 1'b0;
        case (state)
            IDLE: begin
                if (act) begin
                    next_state = COUNT;
                end else if (i_trigger_return) begin
                    next_state = RETURN;
                end
            end
            COUNT: begin
                if (!act && (i_trigger_return || (o_wait_time == 32'd0))) begin
                    next_state = RETURN;
                end
            end
            RETURN: begin
                o_busy = 1'b1;
                if (!o_return_valid && !sel_found) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                o_return_done = 1'b1;
                next_state    = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Timer, balance latch and coin offer; an accepted offer costs one idle cycle for re-selection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_wait_time    <= WAIT_LOAD;
            remaining      <= '0;
            o_remainder    <= '0;
            o_return_valid <= 1'b0;
            o_return_coin  <= '0;
            cur_idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_wait_time <= WAIT_LOAD;
                    if (next_state == RETURN) begin
                        o_wait_time <= 32'd0;
                        remaining   <= i_current_total;
                    end
                end
                COUNT: begin
                    if (act) begin
                        o_wait_time <= WAIT_LOAD;
                    end else if (next_state == RETURN) begin
                        o_wait_time <= 32'd0;
                        remaining   <= i_current_total;
                    end else begin
                        o_wait_time <= o_wait_time - 32'd1;
                    end
                end
                RETURN: begin
                    if (accept) begin
                        remaining      <= remaining - TOTAL_BITS'(cur_value);
                        o_return_valid <= 1'b0;
                        o_return_coin  <= '0;
                    end else if (o_return_valid) begin
                        if (withdraw) begin
                            o_return_valid <= 1'b0;
                            o_return_coin  <= '0;
                        end
                    end else if (sel_found) begin
                        o_return_valid <= 1'b1;
                        o_return_coin  <= NUM_COINS'(1) << sel_idx;
                        cur_idx        <= sel_idx;
                    end else begin
                        o_remainder <= remaining;
                        o_wait_time <= WAIT_LOAD;
                    end
                end
                DONE: begin
                    o_wait_time <= WAIT_LOAD;
                end
                default: begin
                    o_wait_time <= WAIT_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_return_sequencer.sv
// tb/tb_coin_return_sequencer.sv - scoreboard bench for coin_return_sequencer
module tb_coin_return_sequencer;

    localparam int NC = 3;
    localparam int TB = 31;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [32*NC-1:0] coin_value;
    logic [NC-1:0]   input_coin = '0;
    logic            output_item = 1'b0;
    logic            trigger_return = 1'b0;
    logic [TB-1:0]   current_total = '0;
    logic [NC-1:0]   return_coin;
    logic            return_valid;
    logic            return_ready = 1'b1;
    logic            busy;
    logic            return_done;
    logic [TB-1:0]   remainder;
    logic [31:0]     wait_time;
`ifdef COIN_STOCK_EN
    logic [NC-1:0]   coin_empty = '0;
`endif

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    logic [NC-1:0] exp_coins[$];
    logic [TB-1:0] exp_rem[$];

    assign coin_value = {32'd1000, 32'd500, 32'd100};

    coin_return_sequencer #(.NUM_COINS(NC), .TOTAL_BITS(TB), .WAIT_CYCLES(10)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_coin_value     (coin_value),
        .i_input_coin     (input_coin),
        .i_output_item    (output_item),
        .i_trigger_return (trigger_return),
        .i_current_total  (current_total),
`ifdef COIN_STOCK_EN
        .i_coin_empty     (coin_empty),
`endif
        .o_return_coin    (return_coin),
        .o_return_valid   (return_valid),
        .i_return_ready   (return_ready),
        .o_busy           (busy),
        .o_return_done    (return_done),
        .o_remainder      (remainder),
        .o_wait_time      (wait_time)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int start;
        int n;
        start = done_seen;
        n = 0;
        while (done_seen == start && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", 32'(done_seen > start), 32'd1);
    endtask

    task automatic pulse_coin(input logic [NC-1:0] c);
        input_coin = c;
        tick();
        input_coin = '0;
    endtask

    // Monitor: pop expected coin on every handshake, expected remainder on every done pulse
    always @(negedge clk) begin
        if (reset_n) begin
            if (return_valid && return_ready) begin
                if (exp_coins.size() == 0) begin
                    chk("unexpected_coin", 32'(return_coin), 32'd0);
                end else begin
                    chk("coin", 32'(return_coin), 32'(exp_coins.pop_front()));
                end
            end
            if (return_done) begin
                done_seen++;
                chk("done_busy", 32'(busy), 32'd0);
                if (exp_rem.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("remainder", 32'(remainder), 32'(exp_rem.pop_front()));
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_wait", wait_time, 32'd10);
        chk("rst_valid", 32'(return_valid), 32'd0);
        chk("rst_coin", 32'(return_coin), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(return_done), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Timeout path: 1600 -> 1000, 500, 100
        current_total = 31'd1600;
        return_ready = 1'b1;
        exp_coins.push_back(3'b100);
        exp_coins.push_back(3'b010);
        exp_coins.push_back(3'b001);
        exp_rem.push_back(31'd0);
        pulse_coin(3'b010);
        for (int i = 10; i >= 0; i--) begin
            chk("countdown", wait_time, 32'(i));
            chk("countdown_busy", 32'(busy), 32'd0);
            tick();
        end
        chk("timeout_busy", 32'(busy), 32'd1);
        chk("return_wait", wait_time, 32'd0);
        wait_done(40);
        tick();
        chk("after_done_wait", wait_time, 32'd10);

        // Trigger with dispenser stalled: 700 -> 500 held, then 100, 100
        current_total = 31'd700;
        return_ready = 1'b0;
        exp_coins.push_back(3'b010);
        exp_coins.push_back(3'b001);
        exp_coins.push_back(3'b001);
        exp_rem.push_back(31'd0);
        pulse_coin(3'b001);
        tick();
        trigger_return = 1'b1;
        tick();
        trigger_return = 1'b0;
        chk("trig_busy", 32'(busy), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(return_valid), 32'd1);
            chk("stall_coin", 32'(return_coin), 32'b010);
            tick();
        end
        return_ready = 1'b1;
        wait_done(40);
        tick();

        // Activity beats trigger in the same cycle
        pulse_coin(3'b001);
        tick();
        tick();
        chk("pre_reload_wait", wait_time, 32'd8);
        input_coin = 3'b100;
        trigger_return = 1'b1;
        tick();
        input_coin = '0;
        trigger_return = 1'b0;
        chk("reload_wait", wait_time, 32'd10);
        chk("reload_busy", 32'(busy), 32'd0);
        tick();
        chk("dropped_trig_wait", wait_time, 32'd9);
        chk("dropped_trig_busy", 32'(busy), 32'd0);

        // Unpayable balance: 50 -> no offers, remainder 50
        current_total = 31'd50;
        exp_rem.push_back(31'd50);
        trigger_return = 1'b1;
        tick();
        trigger_return = 1'b0;
        chk("small_busy", 32'(busy), 32'd1);
        chk("small_done_early", 32'(return_done), 32'd0);
        tick();
        chk("small_done", 32'(return_done), 32'd1);
        chk("small_valid", 32'(return_valid), 32'd0);
        tick();
        chk("small_rem_held", 32'(remainder), 32'd50);

        // Asynchronous reset mid-RETURN
        current_total = 31'd1600;
        return_ready = 1'b0;
        trigger_return = 1'b1;
        tick();
        trigger_return = 1'b0;
        tick();
        chk("pre_abort_valid", 32'(return_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_valid", 32'(return_valid), 32'd0);
        chk("abort_coin", 32'(return_coin), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wait", wait_time, 32'd10);
        chk("abort_remainder", 32'(remainder), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        return_ready = 1'b1;
        tick();
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_wait", wait_time, 32'd10);

`ifdef COIN_STOCK_EN
        // Empty 1000 dispenser: 1200 -> 500, 500, 100, 100
        coin_empty = 3'b100;
        current_total = 31'd1200;
        exp_coins.push_back(3'b010);
        exp_coins.push_back(3'b010);
        exp_coins.push_back(3'b001);
        exp_coins.push_back(3'b001);
        exp_rem.push_back(31'd0);
        trigger_return = 1'b1;
        tick();
        trigger_return = 1'b0;
        wait_done(40);
        tick();
        coin_empty = '0;
`endif

        chk("coins_drained", 32'(exp_coins.size()), 32'd0);
        chk("dones_drained", 32'(exp_rem.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
